// File: rtl/sn_reg_decoder.sv
// ---------------------------------------------------------------------------
// sn_reg_decoder
//   CPU-side write decoder for an SN76489-compatible PSG. It accepts byte
//   writes using the latch/data protocol, holds the eight internal registers
//   (three 10-bit tone periods, noise control and four attenuators), and
//   drives them to the tone, noise and attenuator channels. READY is modelled
//   as a busy window of BUSY_CYCLES clocks after every accepted write.
//
// Parameters
//   BUSY_CYCLES  clocks READY stays low after an accepted write (0 = never)
//
// Ports
//   clk          system clock, all logic on posedge
//   rst_n        asynchronous active-low reset
//   wr_en        write request (level), accepted when wr_en & ready
//   wr_data[7:0] write byte, sampled with wr_en
//   ready        1 = a write presented this cycle is accepted
//   wr_drop      1-cycle pulse after a write that was discarded while busy
//   toneN_freq   10-bit tone period, channels 0..2
//   noise_ctrl   [2] white(1)/periodic(0), [1:0] shift rate select
//   noise_rst    1-cycle pulse after every write to the noise register
//   atten0..3    4-bit attenuation per channel (3 = noise), 4'hF = off
// ---------------------------------------------------------------------------
module sn_reg_decoder #(
  parameter int unsigned BUSY_CYCLES = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wr_en,
  input  logic [7:0] wr_data,
  output logic       ready,
  output logic       wr_drop,
  output logic [9:0] tone0_freq,
  output logic [9:0] tone1_freq,
  output logic [9:0] tone2_freq,
  output logic [2:0] noise_ctrl,
  output logic       noise_rst,
  output logic [3:0] atten0,
  output logic [3:0] atten1,
  output logic [3:0] atten2,
  output logic [3:0] atten3
);

  localparam bit          HAS_BUSY = (BUSY_CYCLES != 0);
  localparam int unsigned CNT_W    = HAS_BUSY ? $clog2(BUSY_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD =
    CNT_W'(HAS_BUSY ? (BUSY_CYCLES - 1) : 0);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_BUSY = 1'b1;

  localparam logic [1:0] CH_NOISE = 2'd3;

  // State
  logic [0:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_latch;       // {chan, type} of the latched register
  logic [9:0]       r_tone  [0:2];
  logic [3:0]       r_atten [0:3];
  logic [2:0]       r_noise_ctrl;
  logic             r_noise_rst;
  logic             r_wr_drop;

  // Decode
  logic       w_ready;
  logic       w_accept;
  logic [2:0] w_target;
  logic [1:0] w_chan;
  logic       w_is_atten;
  logic       w_is_noise;
  logic       w_is_tone;

  assign w_ready  = (r_state == S_IDLE);
  assign w_accept = wr_en & w_ready;

  // A latch byte names its own target; a data byte goes to the latched one.
  assign w_target   = wr_data[7] ? wr_data[6:4] : r_latch;
  assign w_chan     = w_target[2:1];
  assign w_is_atten = w_target[0];
  assign w_is_noise = ~w_is_atten & (w_chan == CH_NOISE);
  assign w_is_tone  = ~w_is_atten & (w_chan != CH_NOISE);

  // Busy window: the load value is BUSY_CYCLES-1 and the exit happens on the
  // edge that sees zero, which gives exactly BUSY_CYCLES cycles of ready=0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept && HAS_BUSY) begin
            r_state <= S_BUSY;
            r_cnt   <= CNT_LOAD;
          end
        end
        S_BUSY: begin
          if (r_cnt == '0) begin
            r_state <= S_IDLE;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  // Latched register address (only latch bytes move it)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_latch <= '0;
    end else if (w_accept && wr_data[7]) begin
      r_latch <= wr_data[6:4];
    end
  end

  // Tone periods: latch byte writes the low nibble, data byte the high six
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < 3; i++) begin
        r_tone[i] <= '0;
      end
    end else if (w_accept && w_is_tone) begin
      for (int unsigned i = 0; i < 3; i++) begin
        if (w_chan == 2'(i)) begin
          if (wr_data[7]) begin
            r_tone[i] <= {r_tone[i][9:4], wr_data[3:0]};
          end else begin
            r_tone[i] <= {wr_data[5:0], r_tone[i][3:0]};
          end
        end
      end
    end
  end

  // Attenuators: both byte kinds carry the value in bits [3:0]
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < 4; i++) begin
        r_atten[i] <= '1;
      end
    end else if (w_accept && w_is_atten) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (w_chan == 2'(i)) begin
          r_atten[i] <= wr_data[3:0];
        end
      end
    end
  end

  // Noise control and its restart pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_noise_ctrl <= '0;
      r_noise_rst  <= 1'b0;
    end else begin
      r_noise_rst <= w_accept & w_is_noise;
      if (w_accept && w_is_noise) begin
        r_noise_ctrl <= wr_data[2:0];
      end
    end
  end

  // Discarded-write indication, one pulse per offending cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_drop <= 1'b0;
    end else begin
      r_wr_drop <= wr_en & ~w_ready;
    end
  end

  assign ready      = w_ready;
  assign wr_drop    = r_wr_drop;
  assign tone0_freq = r_tone[0];
  assign tone1_freq = r_tone[1];
  assign tone2_freq = r_tone[2];
  assign noise_ctrl = r_noise_ctrl;
  assign noise_rst  = r_noise_rst;
  assign atten0     = r_atten[0];
  assign atten1     = r_atten[1];
  assign atten2     = r_atten[2];
  assign atten3     = r_atten[3];

endmodule
